// File: rtl/soc_uart_pkg.sv
// Shared types and constants for the UART transmit port.
// Holds the frame FSM encoding, default timing/depth and status word layout.
package soc_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // 100 MHz system clock at 115200 baud
    localparam int unsigned DEF_BAUD_DIV   = 868;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    // Status word: flags in the top bits, occupancy in the low bits
    localparam int unsigned STAT_OVF_BIT  = 31;
    localparam int unsigned STAT_FULL_BIT = 30;
    localparam int unsigned STAT_BUSY_BIT = 29;

endpackage

// File: rtl/uart_tx_port_if.sv
// Bus-facing signal bundle of the UART transmit port.
// The master side is the bus/CPU, the slave side is the transmitter.
interface uart_tx_port_if
    import soc_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          uart_we;
    logic [7:0]    uart_data;
    logic          ovf_clr;
    logic          tx;
    logic          busy;
    logic          fifo_full;
    logic [CW-1:0] fifo_cnt;
    logic          overflow;
    logic [31:0]   status;

    modport master (
        output uart_we, uart_data, ovf_clr,
        input  tx, busy, fifo_full, fifo_cnt, overflow, status
    );

    modport slave (
        input  uart_we, uart_data, ovf_clr,
        output tx, busy, fifo_full, fifo_cnt, overflow, status
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; occupancy is kept in its own counter
// so a full FIFO is never confused with an empty one when the pointers meet.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          RSTN,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          full_r;
    logic          empty_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests and compute the next occupancy
    always_comb begin
        pop_ok_s     = pop && (count_r != {CW{1'b0}});
        push_ok_s    = push && ((count_r != DEPTH_C) || pop_ok_s);
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered full/empty flags
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_C);
            empty_r <= (count_next_s == {CW{1'b0}});
        end
    end

    // Storage needs no reset: an empty count makes stale bytes unreachable
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/uart_tx_port.sv
// 8N1 UART transmitter with a byte FIFO, sticky overflow flag and status word.
// The line output lags the FSM state by one register stage.
module uart_tx_port
    import soc_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          RSTN,
    uart_tx_port_if.slave bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    tx_state_t     state_r;
    logic [BW-1:0] baud_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          busy_r;
    logic          overflow_r;

    logic          baud_end_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          tx_next_s;
    logic [7:0]    fifo_rdata_s;
    logic [CW-1:0] fifo_cnt_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [31:0]   status_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .RSTN  (RSTN),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bus.uart_data),
        .rdata (fifo_rdata_s),
        .count (fifo_cnt_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands
    always_comb begin
        baud_end_s = (baud_cnt_r == BAUD_LAST);
        pop_s      = !fifo_empty_s &&
                     ((state_r == ST_IDLE) || ((state_r == ST_STOP) && baud_end_s));
        push_s     = bus.uart_we && (!fifo_full_s || pop_s);
        drop_s     = bus.uart_we && fifo_full_s && !pop_s;
    end

    // Line level for the current state
    always_comb begin
        tx_next_s = 1'b1;
        case (state_r)
            ST_START: tx_next_s = 1'b0;
            ST_DATA:  tx_next_s = shift_r[0];
            ST_STOP:  tx_next_s = 1'b1;
            default:  tx_next_s = 1'b1;
        endcase
    end

    // Frame sequencer with baud/bit counters and registered outputs
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {BW{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            tx_r   <= tx_next_s;
            busy_r <= (state_r != ST_IDLE) || !fifo_empty_s;

            // A dropped write in the same cycle as a clear keeps the flag set
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end

            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= {BW{1'b0}};
                    bit_cnt_r  <= 3'd0;
                    if (!fifo_empty_s) begin
                        shift_r <= fifo_rdata_s;
                        state_r <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        state_r    <= ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        shift_r    <= {1'b0, shift_r[7:1]};
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        if (!fifo_empty_s) begin
                            shift_r <= fifo_rdata_s;
                            state_r <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= {BW{1'b0}};
                    bit_cnt_r  <= 3'd0;
                end
            endcase
        end
    end

    // Status readback word assembled from registered flags
    always_comb begin
        status_s                = 32'h0000_0000;
        status_s[CW-1:0]        = fifo_cnt_s;
        status_s[STAT_BUSY_BIT] = busy_r;
        status_s[STAT_FULL_BIT] = fifo_full_s;
        status_s[STAT_OVF_BIT]  = overflow_r;
    end

    assign bus.tx        = tx_r;
    assign bus.busy      = busy_r;
    assign bus.fifo_full = fifo_full_s;
    assign bus.fifo_cnt  = fifo_cnt_s;
    assign bus.overflow  = overflow_r;
    assign bus.status    = status_s;

endmodule
